// File: rtl/param_cpu_core.sv
// Multi-cycle 16-bit-instruction CPU core with a parameterised datapath.
// It uses a FETCH/DECODE/EXEC/MEM/HALT control unit and a req/ack memory port.
module param_cpu_core #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  input  logic [2:0]        reg_select,
  output logic [DATA_W-1:0] reg_out,
  output logic [ADDR_W-1:0] PC_out,
  output logic [15:0]       IR_out,
  output logic              zero_flag,
  output logic [2:0]        CU_state,
  output logic              halted
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_HALT   = 3'd4
  } state_t;

  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_AND  = 4'h2;
  localparam logic [3:0] OP_OR   = 4'h3;
  localparam logic [3:0] OP_XOR  = 4'h4;
  localparam logic [3:0] OP_SLT  = 4'h5;
  localparam logic [3:0] OP_ADDI = 4'h6;
  localparam logic [3:0] OP_LD   = 4'h7;
  localparam logic [3:0] OP_ST   = 4'h8;
  localparam logic [3:0] OP_BEQ  = 4'h9;
  localparam logic [3:0] OP_BNE  = 4'hA;
  localparam logic [3:0] OP_JMP  = 4'hB;
  localparam logic [3:0] OP_HALT = 4'hF;

  state_t             r_state;
  logic [ADDR_W-1:0]  r_pc;
  logic [15:0]        r_ir;
  logic               r_zero;
  logic               r_halted;
  logic               r_mem_req;
  logic               r_mem_we;
  logic [ADDR_W-1:0]  r_mem_addr;
  logic [DATA_W-1:0]  r_mem_wdata;
  logic [DATA_W-1:0]  r_op_a;
  logic [DATA_W-1:0]  r_op_b;

  logic [3:0]         w_op;
  logic [2:0]         w_rd;
  logic [2:0]         w_rs;
  logic [2:0]         w_rt;
  logic [DATA_W-1:0]  w_imm;
  logic [DATA_W-1:0]  w_alu;
  logic               w_is_alu;
  logic               w_eq;
  logic [ADDR_W-1:0]  w_ea;
  logic [ADDR_W-1:0]  w_br_pc;
  logic [ADDR_W-1:0]  w_jmp_pc;
  logic [ADDR_W-1:0]  w_next_pc;
  logic               w_xfer;
  logic               w_rf_we;
  logic [DATA_W-1:0]  w_rf_data;
  logic [DATA_W-1:0]  w_regs [8];

  assign w_op     = r_ir[15:12];
  assign w_rd     = r_ir[11:9];
  assign w_rs     = r_ir[8:6];
  assign w_rt     = r_ir[5:3];
  assign w_imm    = {{(DATA_W-6){r_ir[5]}}, r_ir[5:0]};
  assign w_is_alu = (w_op <= OP_ADDI);
  assign w_eq     = (r_op_a == r_op_b);
  assign w_xfer   = r_mem_req && mem_ack;

  // Low ADDR_W bits of a sum depend only on the low ADDR_W bits of the operands.
  assign w_ea    = r_op_a[ADDR_W-1:0] + w_imm[ADDR_W-1:0];
  assign w_br_pc = r_pc + w_imm[ADDR_W-1:0];

  generate
    if (ADDR_W <= 12) begin : g_jmp_trunc
      assign w_jmp_pc = r_ir[ADDR_W-1:0];
    end else begin : g_jmp_zext
      assign w_jmp_pc = {{(ADDR_W-12){1'b0}}, r_ir[11:0]};
    end
  endgenerate

  always_comb begin
    w_alu = '0;
    case (w_op)
      OP_ADD:  w_alu = r_op_a + r_op_b;
      OP_SUB:  w_alu = r_op_a - r_op_b;
      OP_AND:  w_alu = r_op_a & r_op_b;
      OP_OR:   w_alu = r_op_a | r_op_b;
      OP_XOR:  w_alu = r_op_a ^ r_op_b;
      OP_SLT:  w_alu = {{(DATA_W-1){1'b0}}, ($signed(r_op_a) < $signed(r_op_b))};
      OP_ADDI: w_alu = r_op_a + w_imm;
      default: w_alu = '0;
    endcase
  end

  always_comb begin
    w_next_pc = r_pc;
    case (w_op)
      OP_BEQ:  w_next_pc = w_eq ? w_br_pc : r_pc;
      OP_BNE:  w_next_pc = w_eq ? r_pc : w_br_pc;
      OP_JMP:  w_next_pc = w_jmp_pc;
      default: w_next_pc = r_pc;
    endcase
  end

  assign w_rf_we   = ((r_state == S_EXEC) && w_is_alu) ||
                     ((r_state == S_MEM) && (w_op == OP_LD) && w_xfer);
  assign w_rf_data = (r_state == S_MEM) ? mem_rdata : w_alu;

  // R0 is hard-wired to zero; R1..R7 are individual registers.
  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_rf
      if (gi == 0) begin : g_zero
        assign w_regs[gi] = '0;
      end else begin : g_reg
        logic [DATA_W-1:0] r_reg;
        always_ff @(posedge clk or negedge reset_n) begin
          if (!reset_n) begin
            r_reg <= '0;
          end else if (w_rf_we && (w_rd == 3'(gi))) begin
            r_reg <= w_rf_data;
          end
        end
        assign w_regs[gi] = r_reg;
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= S_FETCH;
      r_pc        <= '0;
      r_ir        <= '0;
      r_zero      <= 1'b0;
      r_halted    <= 1'b0;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_op_a      <= '0;
      r_op_b      <= '0;
    end else begin
      case (r_state)
        S_FETCH: begin
          if (w_xfer) begin
            r_ir      <= mem_rdata[15:0];
            r_pc      <= r_pc + ADDR_W'(1);
            r_mem_req <= 1'b0;
            r_state   <= S_DECODE;
          end else begin
            // Only reached without a request right after reset.
            r_mem_req  <= 1'b1;
            r_mem_we   <= 1'b0;
            r_mem_addr <= r_pc;
          end
        end
        S_DECODE: begin
          r_op_a <= w_regs[w_rs];
          r_op_b <= ((w_op == OP_ST) || (w_op == OP_BEQ) || (w_op == OP_BNE)) ?
                    w_regs[w_rd] : w_regs[w_rt];
          r_state <= S_EXEC;
        end
        S_EXEC: begin
          if ((w_op == OP_LD) || (w_op == OP_ST)) begin
            r_mem_req   <= 1'b1;
            r_mem_we    <= (w_op == OP_ST);
            r_mem_addr  <= w_ea;
            r_mem_wdata <= r_op_b;
            r_state     <= S_MEM;
          end else if (w_op == OP_HALT) begin
            r_halted <= 1'b1;
            r_state  <= S_HALT;
          end else begin
            if (w_is_alu) begin
              r_zero <= (w_alu == '0);
            end
            // Next fetch is issued on this edge so ALU/branch ops take 3 cycles.
            r_pc       <= w_next_pc;
            r_mem_req  <= 1'b1;
            r_mem_we   <= 1'b0;
            r_mem_addr <= w_next_pc;
            r_state    <= S_FETCH;
          end
        end
        S_MEM: begin
          if (w_xfer) begin
            r_mem_req  <= 1'b1;
            r_mem_we   <= 1'b0;
            r_mem_addr <= r_pc;
            r_state    <= S_FETCH;
          end
        end
        S_HALT: begin
          r_state <= S_HALT;
        end
        default: begin
          r_mem_req <= 1'b0;
          r_state   <= S_FETCH;
        end
      endcase
    end
  end

  assign mem_req   = r_mem_req;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign reg_out   = w_regs[reg_select];
  assign PC_out    = r_pc;
  assign IR_out    = r_ir;
  assign zero_flag = r_zero;
  assign CU_state  = r_state;
  assign halted    = r_halted;

endmodule

// File: tb/tb_param_cpu_core.sv
// Directed bench for param_cpu_core: small programs run against a req/ack memory
// model with programmable wait states, plus a 6-bit-address instance for PC wrap.
module tb_param_cpu_core;

  localparam int DW  = 16;
  localparam int AW  = 8;
  localparam int AW2 = 6;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           reset_n = 1'b0;
  logic           mem_req, mem_we, mem_ack;
  logic [AW-1:0]  mem_addr, pc_out;
  logic [DW-1:0]  mem_wdata, mem_rdata, reg_out;
  logic [2:0]     reg_select = 3'd0;
  logic [15:0]    ir_out;
  logic           zero_flag, halted;
  logic [2:0]     cu_state;

  logic           rst2_n = 1'b0;
  logic           mem_req2, mem_we2, mem_ack2;
  logic [AW2-1:0] mem_addr2, pc_out2;
  logic [DW-1:0]  mem_wdata2, mem_rdata2, reg_out2;
  logic [15:0]    ir_out2;
  logic           zero_flag2, halted2;
  logic [2:0]     cu_state2;

  logic [DW-1:0]  mem  [256];
  logic [DW-1:0]  mem2 [64];
  int             wait_n = 0;
  int             wait_cnt = 0;
  logic           ld_en = 1'b0, ld2_en = 1'b0, ld_clr = 1'b0;
  logic [7:0]     ld_addr = 8'd0;
  logic [15:0]    ld_data = 16'd0;

  int n_tests = 0;
  int n_fail  = 0;

  param_cpu_core #(.DATA_W(DW), .ADDR_W(AW)) u_dut (
    .clk(clk), .reset_n(reset_n),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .reg_select(reg_select), .reg_out(reg_out),
    .PC_out(pc_out), .IR_out(ir_out), .zero_flag(zero_flag),
    .CU_state(cu_state), .halted(halted)
  );

  param_cpu_core #(.DATA_W(DW), .ADDR_W(AW2)) u_dut_a6 (
    .clk(clk), .reset_n(rst2_n),
    .mem_req(mem_req2), .mem_we(mem_we2), .mem_addr(mem_addr2), .mem_wdata(mem_wdata2),
    .mem_rdata(mem_rdata2), .mem_ack(mem_ack2),
    .reg_select(3'd0), .reg_out(reg_out2),
    .PC_out(pc_out2), .IR_out(ir_out2), .zero_flag(zero_flag2),
    .CU_state(cu_state2), .halted(halted2)
  );

  // Memory model: combinational read data, ack after wait_n waiting cycles.
  assign mem_rdata = mem[mem_addr];
  assign mem_ack   = mem_req && (wait_cnt >= wait_n);

  always @(posedge clk) begin
    if (!reset_n || (mem_req && mem_ack)) wait_cnt <= 0;
    else if (mem_req)                     wait_cnt <= wait_cnt + 1;
  end

  always @(posedge clk) begin
    if (ld_clr) begin
      for (int i = 0; i < 256; i++) mem[i] <= '0;
    end else if (ld_en) begin
      mem[ld_addr] <= ld_data;
    end else if (reset_n && mem_req && mem_ack && mem_we) begin
      mem[mem_addr] <= mem_wdata;
    end
  end

  assign mem_rdata2 = mem2[mem_addr2];
  assign mem_ack2   = mem_req2;

  always @(posedge clk) begin
    if (ld_clr) begin
      for (int i = 0; i < 64; i++) mem2[i] <= '0;
    end else if (ld2_en) begin
      mem2[ld_addr[5:0]] <= ld_data;
    end
  end

  function automatic logic [15:0] enc(input logic [3:0] op, input logic [2:0] a,
                                      input logic [2:0] b, input logic [5:0] c);
    return {op, a, b, c};
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  task automatic put(input logic [7:0] a, input logic [15:0] d, input logic second);
    ld_addr = a;
    ld_data = d;
    ld_en   = !second;
    ld2_en  = second;
    @(posedge clk); #1;
    ld_en   = 1'b0;
    ld2_en  = 1'b0;
  endtask

  task automatic clear_mem();
    ld_clr = 1'b1;
    @(posedge clk); #1;
    ld_clr = 1'b0;
  endtask

  task automatic wait_halt(input int budget, output int cyc);
    cyc = 0;
    for (int c = 1; c <= budget; c++) begin
      @(posedge clk); #1;
      if (halted) begin
        cyc = c;
        break;
      end
    end
  endtask

  task automatic check_reg(input string tag, input logic [2:0] idx, input logic [15:0] exp);
    reg_select = idx;
    #1;
    check_eq(tag, 32'(reg_out), 32'(exp));
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int cyc;
    int found;
    int n;
    int got_a[6];
    int exp_a[6];
    int got_b[4];
    int exp_b[4];

    // ---- Program 1: ADDI/ADDI/ADD/HALT, zero-wait memory ----
    clear_mem();
    put(8'd0, enc(4'h6, 3'd1, 3'd0, 6'd5), 1'b0);
    put(8'd1, enc(4'h6, 3'd2, 3'd0, 6'h3B), 1'b0);
    put(8'd2, enc(4'h0, 3'd3, 3'd1, 6'b010_000), 1'b0);
    put(8'd3, 16'hF000, 1'b0);
    check_eq("rst_mem_req", 32'(mem_req), 32'd0);
    check_eq("rst_pc", 32'(pc_out), 32'd0);
    check_eq("rst_state", 32'(cu_state), 32'd0);
    check_eq("rst_halted", 32'(halted), 32'd0);

    @(negedge clk) reset_n = 1'b1;
    @(posedge clk); #1;
    check_eq("first_req", 32'(mem_req), 32'd1);
    check_eq("first_addr", 32'(mem_addr), 32'd0);
    check_eq("first_we", 32'(mem_we), 32'd0);
    wait_halt(40, cyc);
    check_eq("p1_halt_cycles", 32'(cyc), 32'd12);
    check_reg("p1_r1", 3'd1, 16'h0005);
    check_reg("p1_r2", 3'd2, 16'hFFFB);
    check_reg("p1_r3", 3'd3, 16'h0000);
    check_eq("p1_zero_flag", 32'(zero_flag), 32'd1);
    check_eq("p1_pc", 32'(pc_out), 32'd4);
    check_eq("p1_state", 32'(cu_state), 32'd4);
    repeat (5) @(posedge clk);
    #1;
    check_eq("p1_hold_pc", 32'(pc_out), 32'd4);
    check_eq("p1_hold_req", 32'(mem_req), 32'd0);
    check_eq("p1_hold_halted", 32'(halted), 32'd1);

    // ---- Asynchronous reset clears a halted core at once ----
    #2 reset_n = 1'b0;
    #1;
    check_eq("areset_halted", 32'(halted), 32'd0);
    check_eq("areset_zero", 32'(zero_flag), 32'd0);
    check_eq("areset_ir", 32'(ir_out), 32'd0);
    check_eq("areset_pc", 32'(pc_out), 32'd0);
    check_reg("areset_r1", 3'd1, 16'h0000);

    // ---- Program 2: ST/LD with 3 wait states, R0 write, SLT ----
    wait_n = 3;
    clear_mem();
    put(8'd0, enc(4'h6, 3'd1, 3'd0, 6'd5), 1'b0);
    put(8'd1, enc(4'h8, 3'd1, 3'd0, 6'd10), 1'b0);
    put(8'd2, enc(4'h7, 3'd4, 3'd0, 6'd10), 1'b0);
    put(8'd3, enc(4'h6, 3'd2, 3'd0, 6'h3B), 1'b0);
    put(8'd4, enc(4'h6, 3'd0, 3'd0, 6'd7), 1'b0);
    put(8'd5, enc(4'h5, 3'd5, 3'd2, 6'b001_000), 1'b0);
    put(8'd6, 16'hF000, 1'b0);
    @(negedge clk) reset_n = 1'b1;
    found = 0;
    for (int c = 0; c < 300; c++) begin
      @(posedge clk); #1;
      if (mem_req && mem_we) begin
        found = 1;
        break;
      end
    end
    check_eq("st_seen", 32'(found), 32'd1);
    check_eq("st_addr", 32'(mem_addr), 32'd10);
    check_eq("st_wdata", 32'(mem_wdata), 32'd5);
    for (int k = 1; k <= 3; k++) begin
      @(posedge clk); #1;
      check_eq($sformatf("st_hold%0d_req", k), 32'(mem_req && mem_we), 32'd1);
      check_eq($sformatf("st_hold%0d_addr", k), 32'(mem_addr), 32'd10);
      check_eq($sformatf("st_hold%0d_wdata", k), 32'(mem_wdata), 32'd5);
    end
    wait_halt(400, cyc);
    check_eq("p2_halted", 32'(halted), 32'd1);
    check_eq("p2_mem10", 32'(mem[10]), 32'd5);
    check_reg("p2_r4_ld", 3'd4, 16'h0005);
    check_reg("p2_r0", 3'd0, 16'h0000);
    check_reg("p2_r5_slt", 3'd5, 16'h0001);
    check_eq("p2_zero_flag", 32'(zero_flag), 32'd0);
    check_eq("p2_pc", 32'(pc_out), 32'd7);

    // ---- Program 3: BNE falls through, BEQ loops back to itself ----
    reset_n = 1'b0;
    wait_n  = 0;
    clear_mem();
    put(8'd0, enc(4'h6, 3'd1, 3'd0, 6'd5), 1'b0);
    put(8'd1, enc(4'hA, 3'd1, 3'd1, 6'h3F), 1'b0);
    put(8'd2, 16'hC000, 1'b0);
    put(8'd3, enc(4'h9, 3'd1, 3'd1, 6'h3F), 1'b0);
    exp_a = '{0, 1, 2, 3, 3, 3};
    got_a = '{-1, -1, -1, -1, -1, -1};
    n = 0;
    @(negedge clk) reset_n = 1'b1;
    for (int c = 0; c < 200 && n < 6; c++) begin
      @(posedge clk); #1;
      if (mem_req && mem_ack && !mem_we) begin
        got_a[n] = int'(mem_addr);
        n++;
      end
    end
    for (int i = 0; i < 6; i++) begin
      check_eq($sformatf("br_fetch%0d", i), 32'(got_a[i]), 32'(exp_a[i]));
    end

    // ---- Reset asserted while FETCH waits for ack ----
    wait_n = 5;
    found = 0;
    for (int c = 0; c < 60; c++) begin
      @(posedge clk); #1;
      if (mem_req && !mem_ack && !mem_we && (cu_state == 3'd0)) begin
        found = 1;
        break;
      end
    end
    check_eq("midreq_seen", 32'(found), 32'd1);
    check_eq("midreq_pc", 32'(pc_out), 32'd3);
    #2 reset_n = 1'b0;
    #1;
    check_eq("midreq_rst_req", 32'(mem_req), 32'd0);
    check_eq("midreq_rst_pc", 32'(pc_out), 32'd0);
    check_eq("midreq_rst_state", 32'(cu_state), 32'd0);
    wait_n = 0;
    @(negedge clk) reset_n = 1'b1;
    @(posedge clk); #1;
    check_eq("refetch_req", 32'(mem_req), 32'd1);
    check_eq("refetch_addr", 32'(mem_addr), 32'd0);

    // ---- ADDR_W=6 instance: JMP 63 then NOP wraps PC to 0 ----
    put(8'd0, enc(4'hB, 3'd0, 3'd0, 6'd63), 1'b1);
    put(8'd63, 16'hC000, 1'b1);
    exp_b = '{0, 63, 0, 63};
    got_b = '{-1, -1, -1, -1};
    n = 0;
    @(negedge clk) rst2_n = 1'b1;
    for (int c = 0; c < 100 && n < 4; c++) begin
      @(posedge clk); #1;
      if (mem_req2 && mem_ack2 && !mem_we2) begin
        got_b[n] = int'(mem_addr2);
        n++;
      end
    end
    for (int i = 0; i < 4; i++) begin
      check_eq($sformatf("wrap_fetch%0d", i), 32'(got_b[i]), 32'(exp_b[i]));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
